// File: rtl/glb_pkg.sv
// Shared definitions for the systolic-array result writeback path.
package glb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } wb_state_e;

  localparam int unsigned PE_SIZE_DEF        = 14;
  localparam int unsigned DATA_WIDTH_DEF     = 8;
  localparam int unsigned MEM_DATA_WIDTH_DEF = PE_SIZE_DEF * DATA_WIDTH_DEF;

endpackage

// File: rtl/sa_result_writeback_if.sv
// Array-result input and output-memory write port of the writeback collector.
interface sa_result_writeback_if #(
    parameter int unsigned PE_SIZE        = 14,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MEM_ADDR_WIDTH = 11
);
    localparam int unsigned MEM_DATA_WIDTH = PE_SIZE * DATA_WIDTH;

    logic                          en;
    logic [MEM_ADDR_WIDTH-1:0]     base_addr_i;
    logic [PE_SIZE*DATA_WIDTH-1:0] sa_data_i;
    logic [PE_SIZE-1:0]            sa_valid_i;
    logic                          mem_ce0_o;
    logic                          mem_we0_o;
    logic [MEM_ADDR_WIDTH-1:0]     mem_addr0_o;
    logic [MEM_DATA_WIDTH-1:0]     mem_d0_o;
    logic                          busy_o;
    logic                          done_o;
    logic                          overflow_o;

    modport slave (
        input  en, base_addr_i, sa_data_i, sa_valid_i,
        output mem_ce0_o, mem_we0_o, mem_addr0_o, mem_d0_o, busy_o, done_o, overflow_o
    );

    modport master (
        output en, base_addr_i, sa_data_i, sa_valid_i,
        input  mem_ce0_o, mem_we0_o, mem_addr0_o, mem_d0_o, busy_o, done_o, overflow_o
    );
endinterface

// File: rtl/wb_col_fifo.sv
// Show-ahead per-column deskew FIFO; head data is valid combinationally when not empty.
module wb_col_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    // A full FIFO can still take a push when it pops in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/sa_result_writeback.sv
// Deskews per-column array results and writes each complete row as one memory word.
module sa_result_writeback
    import glb_pkg::*;
#(
    parameter int unsigned PE_SIZE        = PE_SIZE_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned MEM_ADDR_WIDTH = 11,
    parameter int unsigned MEM_DATA_WIDTH = PE_SIZE * DATA_WIDTH,
    parameter int unsigned OUT_ROW_NUM    = 64
) (
    input logic                  clk,
    input logic                  rst,
    sa_result_writeback_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(OUT_ROW_NUM + 1);

    wb_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          row_cnt_q;
    logic [MEM_ADDR_WIDTH-1:0] base_q, addr_q;
    logic [MEM_DATA_WIDTH-1:0] data_q, head;
    logic                      we_q, overflow_q;
    logic                      start, pop_all;
    logic [PE_SIZE-1:0]        push, full, empty;

    for (genvar c = 0; c < PE_SIZE; c++) begin : g_col
        wb_col_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .flush(start),
            .push (push[c]),
            .pop  (pop_all),
            .din  (bus.sa_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
            .dout (head[c*DATA_WIDTH +: DATA_WIDTH]),
            .full (full[c]),
            .empty(empty[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.en) state_d = StRun;
            StRun:   if (row_cnt_q == CNT_W'(OUT_ROW_NUM)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start       = (state_q == StIdle) && bus.en;
        push        = (state_q == StRun) ? bus.sa_valid_i : '0;
        pop_all     = (state_q == StRun) && (&(~empty)) && (row_cnt_q < CNT_W'(OUT_ROW_NUM));
        bus.busy_o  = (state_q != StIdle);
        bus.done_o  = (state_q == StDone);
        bus.mem_we0_o   = we_q;
        bus.mem_ce0_o   = we_q;
        bus.mem_addr0_o = addr_q;
        bus.mem_d0_o    = data_q;
        bus.overflow_o  = overflow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_q  <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            we_q <= pop_all;
            if (start) begin
                base_q     <= bus.base_addr_i;
                row_cnt_q  <= '0;
                overflow_q <= 1'b0;
            end
            if (pop_all) begin
                data_q    <= head;
                addr_q    <= base_q + MEM_ADDR_WIDTH'(row_cnt_q);
                row_cnt_q <= row_cnt_q + CNT_W'(1);
            end
            // Dropped push: the column was full and did not pop this cycle.
            if (|(push & full & ~{PE_SIZE{pop_all}})) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sa_result_writeback.sv
// Directed scoreboard bench: a 64-row instance and a single-row instance share one clock.
module tb_sa_result_writeback;
    typedef struct {
        logic [10:0]  addr;
        logic [111:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   wr_a = 0;
    int   wr_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    sa_result_writeback_if #(.PE_SIZE(14), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(11)) bus_a ();
    sa_result_writeback_if #(.PE_SIZE(14), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(11)) bus_b ();

    sa_result_writeback #(.OUT_ROW_NUM(64)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sa_result_writeback #(.OUT_ROW_NUM(1))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [111:0] row_word(input int b);
        logic [111:0] w;
        for (int c = 0; c < 14; c++) w[c*8 +: 8] = 8'(b + c);
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.mem_we0_o === 1'b1) begin
            wr_a++;
            check("a_ce", bus_a.mem_ce0_o, 1);
            if (q_a.size() == 0) check("a_unexpected_write", q_a.size(), 1);
            else begin
                e = q_a.pop_front();
                check("a_addr", bus_a.mem_addr0_o, e.addr);
                check("a_data", bus_a.mem_d0_o, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.mem_we0_o === 1'b1) begin
            wr_b++;
            check("b_ce", bus_b.mem_ce0_o, 1);
            if (q_b.size() == 0) check("b_unexpected_write", q_b.size(), 1);
            else begin
                e = q_b.pop_front();
                check("b_addr", bus_b.mem_addr0_o, e.addr);
                check("b_data", bus_b.mem_d0_o, e.data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [10:0] base);
        bus_a.base_addr_i = base;
        bus_a.en = 1'b1;
        tick();
        bus_a.en = 1'b0;
        check("a_busy_after_start", bus_a.busy_o, 1);
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (bus_a.done_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, bus_a.done_o, 1);
        tick();
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_ctrl"}, {bus_a.mem_we0_o, bus_a.mem_ce0_o, bus_a.busy_o,
                               bus_a.done_o, bus_a.overflow_o}, 0);
        check({tag, "_addr"}, bus_a.mem_addr0_o, 0);
        check({tag, "_data"}, bus_a.mem_d0_o, 0);
    endtask

    initial begin
        int base_wr;
        int row5;
        bus_a.en = 1'b0; bus_a.base_addr_i = '0; bus_a.sa_data_i = '0; bus_a.sa_valid_i = '0;
        bus_b.en = 1'b0; bus_b.base_addr_i = '0; bus_b.sa_data_i = '0; bus_b.sa_valid_i = '0;

        // Reset and idle behaviour.
        repeat (3) tick();
        check_zero_a("rst_a");
        check("rst_b_ctrl", {bus_b.mem_we0_o, bus_b.busy_o, bus_b.done_o, bus_b.overflow_o}, 0);
        rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check_zero_a("rst_mid_idle");
        tick();
        rst = 1'b0;
        bus_a.sa_valid_i = '1;
        repeat (100) tick();
        bus_a.sa_valid_i = '0;
        check("idle_no_write", wr_a + wr_b, 0);
        check("idle_not_busy", bus_a.busy_o, 0);

        // Aligned single row on the one-row instance.
        bus_b.base_addr_i = 11'h010;
        bus_b.en = 1'b1;
        tick();
        bus_b.en = 1'b0;
        check("b_busy_after_start", bus_b.busy_o, 1);
        q_b.push_back('{11'h010, row_word(1)});
        bus_b.sa_valid_i = '1;
        bus_b.sa_data_i  = row_word(1);
        tick();
        bus_b.sa_valid_i = '0;
        check("b_we_t1", bus_b.mem_we0_o, 0);
        tick();
        check("b_we_t2", bus_b.mem_we0_o, 1);
        check("b_done_t2", bus_b.done_o, 0);
        tick();
        check("b_done_t3", {bus_b.done_o, bus_b.busy_o, bus_b.mem_we0_o}, 3'b110);
        tick();
        check("b_idle_after_done", {bus_b.done_o, bus_b.busy_o}, 0);
        check("b_word_count", wr_b, 1);

        // Skewed stream: column c lags column 0 by c cycles.
        start_a(11'h100);
        for (int r = 0; r < 64; r++) q_a.push_back('{11'(12'h100 + r), row_word(r)});
        base_wr = wr_a;
        for (int k = 0; k <= 76; k++) begin
            for (int c = 0; c < 14; c++) begin
                bus_a.sa_valid_i[c] = (k >= c) && (k - c < 64);
                bus_a.sa_data_i[c*8 +: 8] = 8'(k);
            end
            tick();
            if (k == 13) check("skew_first_latency", bus_a.mem_we0_o, 0);
            if (k >= 14) check("skew_no_bubble", bus_a.mem_we0_o, 1);
        end
        bus_a.sa_valid_i = '0;
        tick();
        check("skew_last_write", {bus_a.mem_we0_o, bus_a.done_o}, 2'b10);
        tick();
        check("skew_done", {bus_a.mem_we0_o, bus_a.done_o, bus_a.busy_o}, 3'b011);
        tick();
        check("skew_idle", bus_a.busy_o, 0);
        check("skew_word_count", wr_a - base_wr, 64);
        check("skew_queue_drained", q_a.size(), 0);

        // Column 5 stalls for 3 cycles mid-stream.
        start_a(11'h200);
        for (int r = 0; r < 64; r++) q_a.push_back('{11'(12'h200 + r), row_word(3 * r)});
        base_wr = wr_a;
        for (int k = 0; k <= 66; k++) begin
            for (int c = 0; c < 14; c++) begin
                if (c == 5) begin
                    row5 = (k < 20) ? k : ((k < 23) ? 64 : k - 3);
                    bus_a.sa_valid_i[c] = (row5 < 64);
                    bus_a.sa_data_i[c*8 +: 8] = 8'(3 * row5 + c);
                end else begin
                    bus_a.sa_valid_i[c] = (k < 64);
                    bus_a.sa_data_i[c*8 +: 8] = 8'(3 * k + c);
                end
            end
            tick();
        end
        bus_a.sa_valid_i = '0;
        wait_done_a("stall_done");
        check("stall_word_count", wr_a - base_wr, 64);
        check("stall_queue_drained", q_a.size(), 0);
        check("stall_no_overflow", bus_a.overflow_o, 0);

        // Overflow: 17 pushes into column 0 only.
        start_a(11'h000);
        base_wr = wr_a;
        for (int i = 0; i < 17; i++) begin
            bus_a.sa_valid_i = 14'h0001;
            bus_a.sa_data_i[7:0] = 8'(i);
            tick();
            if (i == 15) check("ovf_before_17th", bus_a.overflow_o, 0);
            if (i == 16) check("ovf_after_17th", bus_a.overflow_o, 1);
        end
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.addr = 11'(i);
            e.data = {14{8'(8'h40 + i)}};
            e.data[7:0] = 8'(i);
            q_a.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            bus_a.sa_valid_i = 14'h3ffe;
            bus_a.sa_data_i  = {14{8'(8'h40 + i)}};
            tick();
        end
        for (int i = 16; i < 64; i++) begin
            q_a.push_back('{11'(i), {14{8'(8'h80 + i)}}});
            bus_a.sa_valid_i = '1;
            bus_a.sa_data_i  = {14{8'(8'h80 + i)}};
            tick();
        end
        bus_a.sa_valid_i = '0;
        wait_done_a("ovf_run_done");
        check("ovf_word_count", wr_a - base_wr, 64);
        check("ovf_sticky", bus_a.overflow_o, 1);

        // Next start clears overflow; reset mid-run after 10 writes with stale data queued.
        start_a(11'h300);
        check("ovf_cleared_on_start", bus_a.overflow_o, 0);
        for (int k = 0; k < 10; k++) q_a.push_back('{11'(12'h300 + k), row_word(8'h10 + k)});
        base_wr = wr_a;
        for (int k = 0; k <= 12; k++) begin
            if (k < 10) begin
                bus_a.sa_valid_i = '1;
                bus_a.sa_data_i  = row_word(8'h10 + k);
            end else begin
                bus_a.sa_valid_i = 14'h0001;
                bus_a.sa_data_i  = {14{8'hEE}};
            end
            tick();
        end
        bus_a.sa_valid_i = '0;
        check("midrun_writes_before_rst", wr_a - base_wr, 10);
        rst = 1'b1;
        #1;
        check_zero_a("rst_mid_run");
        tick();
        rst = 1'b0;
        check("midrun_queue_drained", q_a.size(), 0);
        start_a(11'h000);
        base_wr = wr_a;
        q_a.push_back('{11'h000, row_word(8'hA0)});
        bus_a.sa_valid_i = '1;
        bus_a.sa_data_i  = row_word(8'hA0);
        tick();
        bus_a.sa_valid_i = '0;
        tick();
        check("fresh_run_we", bus_a.mem_we0_o, 1);
        repeat (3) tick();
        check("fresh_run_word_count", wr_a - base_wr, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sa_result_writeback.md
# sa_result_writeback

Writeback collector on the result side of the systolic array, opposite the global-buffer read path that streams weights and activations into the array. It accepts per-column result bytes as they leave the array's PE_SIZE columns with diagonal skew, and deskews them in per-column FIFOs. Each complete row is packed into one MEM_DATA_WIDTH word and written to the output memory bank at consecutive addresses. It raises a done pulse after OUT_ROW_NUM rows.

## Interface
- PE_SIZE, 14, number of array columns and bytes per memory word
- DATA_WIDTH, 8, result width per column
- FIFO_DEPTH, 16, entries per column deskew FIFO; must be at least PE_SIZE
- MEM_ADDR_WIDTH, 11, output memory address width
- MEM_DATA_WIDTH, 112, output word width; equals PE_SIZE*DATA_WIDTH
- OUT_ROW_NUM, 64, rows written per run
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  start request; sampled in IDLE only
- base_addr_i  in  MEM_ADDR_WIDTH  first write address, latched at start
- sa_data_i  in  PE_SIZE*DATA_WIDTH  column c result in bits [c*DATA_WIDTH +: DATA_WIDTH]
- sa_valid_i  in  PE_SIZE  per-column valid, one result per cycle per column
- mem_ce0_o  out  1  memory chip enable; equals mem_we0_o
- mem_we0_o  out  1  write strobe, one word per cycle
- mem_addr0_o  out  MEM_ADDR_WIDTH  write address
- mem_d0_o  out  MEM_DATA_WIDTH  write data; column 0 in LSBs
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse
- overflow_o  out  1  sticky: a push hit a full FIFO

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when en=1. On that edge: latch base_addr_i, flush all FIFOs, clear row_cnt and overflow_o. sa_valid_i is ignored while in IDLE.
- RUN: column c pushes sa_data_i slice c when sa_valid_i[c]=1 and its FIFO is not full.
- Push into a full FIFO: the data is dropped and overflow_o is set. overflow_o holds until rst or the next start.
- Pop: when every FIFO is non-empty and row_cnt < OUT_ROW_NUM, pop all columns in the same cycle. FIFOs are show-ahead, so head data is valid combinationally.
- Pop cycle: register the packed word, set mem_addr0_o = base + row_cnt, drive mem_we0_o=mem_ce0_o=1 on the next cycle, and increment row_cnt.
- A push and a pop on the same FIFO in the same cycle are both performed; occupancy is unchanged. A full FIFO still accepts a push when it pops in that cycle.
- RUN -> DONE on the edge after the pop that makes row_cnt == OUT_ROW_NUM.
- DONE: one cycle, then IDLE. Data still in the FIFOs at DONE is discarded by the next start flush.
- en while in RUN or DONE: ignored.
- Address arithmetic: modulo 2^MEM_ADDR_WIDTH; wrap-around is silent.

## Timing
- Reset values: every output 0, FIFOs empty, row_cnt 0, state IDLE.
- Reset is asynchronous: outputs go to 0 immediately on rst. A write that was in flight is abandoned.
- Start: en=1 at edge t makes busy_o=1 from t+1.
- Latency: if the last column's push edge is t, mem_we0_o is high during cycle t+2.
- Throughput: one row per cycle while all columns stream; no bubbles.
- Write timing: if the final write is in cycle w, done_o=1 in cycle w+1.
- busy_o is high through the done_o cycle and low in cycle w+2.
- Skew tolerance: column c may lag column 0 by up to FIFO_DEPTH-1 cycles without loss.

## Structure
- Shared package glb_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - default PE_SIZE and DATA_WIDTH constants
  - a derived MEM_DATA_WIDTH check constant
- Sub-module wb_col_fifo: synchronous show-ahead FIFO with push, pop, flush, full, empty and dout; instantiated PE_SIZE times.
- Top level contains only the FSM, row counter, packing register and overflow flag.

## Test plan
- Reset: assert rst mid-idle -> all outputs 0. Release, no en -> no mem_we0_o for 100 cycles.
- Aligned single row, OUT_ROW_NUM=1, base_addr_i=0x010:
  - Stimulus: all 14 valids at edge t, column c data = c+1.
  - Response: mem_we0_o in cycle t+2, addr 0x010, data 0x0E0D…0201. done_o at t+3.
- Skewed stream, 64 rows, base_addr_i=0x100:
  - Stimulus: column c valid on edges t+c..t+c+63, data = (row+c) mod 256.
  - Response: 64 back-to-back writes in cycles t+15..t+78, addr 0x100..0x13F. done_o at t+79.
- Column stall: withhold column 5 for 3 cycles mid-stream, then resume -> writes pause 3 cycles; every word correct and in order; total 64 writes.
- Overflow: in RUN, push 17 values into column 0 only:
  - Response: overflow_o=1 after the 17th push; the first 16 values are retained.
  - Next start clears overflow_o to 0.
- Reset mid-run after 10 writes -> outputs 0 at once. New run with base 0x000 writes row 0 to addr 0x000; no stale FIFO data appears.
